// File: rtl/mantissa_product_normalizer.sv
// mantissa_product_normalizer
//
// Two-stage valid/ready pipeline that normalizes the 56-bit product of two
// 28-bit mantissas (hidden bit at bit 27 of each) to a 28-bit mantissa with
// guard and sticky bits and an adjusted signed scale.
//
//   S1 : captures the raw product, scale and zero flag.
//   S2 : holds the normalized result and drives the out_* ports.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   in_valid/ready  upstream handshake
//   in_prod         unsigned 56-bit mantissa product
//   in_scale        signed sum of operand scales (SCALE_W bits)
//   in_zero         either operand is zero
//   out_valid/ready downstream handshake
//   out_mant        normalized mantissa, hidden bit at bit 27
//   out_scale       adjusted signed scale (SCALE_W+1 bits)
//   out_guard       first bit below out_mant
//   out_sticky      OR of all bits below the guard bit
//   out_zero        result is zero
//   out_err         product had neither bit 55 nor bit 54 set (non-zero operands)
//
// Configuration macro
//   MANT_NORM_STICKY_EN  defined: out_sticky is the OR of the discarded bits.
//                        undefined: out_sticky is tied to 0 and the low product
//                        bits feeding it are not stored at all.

module mantissa_product_normalizer #(
  parameter int unsigned SCALE_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [55:0]               in_prod,
  input  logic signed [SCALE_W-1:0] in_scale,
  input  logic                      in_zero,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [27:0]               out_mant,
  output logic signed [SCALE_W:0]   out_scale,
  output logic                      out_guard,
  output logic                      out_sticky,
  output logic                      out_zero,
  output logic                      out_err
);

  // Lowest product bit that S1 has to keep. Without sticky only the guard
  // candidates (bits 27 and 26) are needed below the mantissa.
`ifdef MANT_NORM_STICKY_EN
  localparam int unsigned ProdLo = 0;
`else
  localparam int unsigned ProdLo = 26;

  logic unused_prod_lo;
  assign unused_prod_lo = ^in_prod[25:0];
`endif

  localparam logic signed [SCALE_W:0] ScaleOne = {{SCALE_W{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_load, s2_load;
  logic s1_capture, s2_capture;

  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    s1_load    = !s1_valid_q || s2_load;
    s1_capture = s1_load && in_valid;
    s2_capture = s2_load && s1_valid_q;
    s1_valid_d = s1_load ? in_valid : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;

  // ---------------------------------------------------------------------------
  // Stage 1: raw capture
  // ---------------------------------------------------------------------------
  logic [55:ProdLo]          s1_prod_q;
  logic signed [SCALE_W-1:0] s1_scale_q;
  logic                      s1_zero_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_scale_q <= '0;
      s1_zero_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_capture) begin
        s1_prod_q  <= in_prod[55:ProdLo];
        s1_scale_q <= in_scale;
        s1_zero_q  <= in_zero;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Normalization (combinational, between S1 and S2)
  // ---------------------------------------------------------------------------
  logic signed [SCALE_W:0] scale_ext;
  logic [27:0]             norm_mant;
  logic signed [SCALE_W:0] norm_scale;
  logic                    norm_guard;
  logic                    norm_zero;
  logic                    norm_err;
`ifdef MANT_NORM_STICKY_EN
  logic                    norm_sticky;
`endif

  assign scale_ext = {s1_scale_q[SCALE_W-1], s1_scale_q};

  always_comb begin
    norm_mant   = '0;
    norm_scale  = '0;
    norm_guard  = 1'b0;
    norm_zero   = 1'b0;
    norm_err    = 1'b0;
`ifdef MANT_NORM_STICKY_EN
    norm_sticky = 1'b0;
`endif
    if (s1_zero_q) begin
      // Zero dominates whatever the product bits say.
      norm_zero = 1'b1;
    end else if (s1_prod_q[55]) begin
      // Product in [2.0, 4.0): shift right by one extra place.
      norm_mant  = s1_prod_q[55:28];
      norm_guard = s1_prod_q[27];
      norm_scale = scale_ext + ScaleOne;
`ifdef MANT_NORM_STICKY_EN
      norm_sticky = |s1_prod_q[26:0];
`endif
    end else if (s1_prod_q[54]) begin
      // Product in [1.0, 2.0): already normalized.
      norm_mant  = s1_prod_q[54:27];
      norm_guard = s1_prod_q[26];
      norm_scale = scale_ext;
`ifdef MANT_NORM_STICKY_EN
      norm_sticky = |s1_prod_q[25:0];
`endif
    end else begin
      // Inputs with hidden bits set can never land here; flag it.
      norm_err = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: output registers
  // ---------------------------------------------------------------------------
  logic [27:0]             s2_mant_q;
  logic signed [SCALE_W:0] s2_scale_q;
  logic                    s2_guard_q;
  logic                    s2_zero_q;
  logic                    s2_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_mant_q  <= '0;
      s2_scale_q <= '0;
      s2_guard_q <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_err_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_capture) begin
        s2_mant_q  <= norm_mant;
        s2_scale_q <= norm_scale;
        s2_guard_q <= norm_guard;
        s2_zero_q  <= norm_zero;
        s2_err_q   <= norm_err;
      end
    end
  end

`ifdef MANT_NORM_STICKY_EN
  logic s2_sticky_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_sticky_q <= 1'b0;
    end else if (s2_capture) begin
      s2_sticky_q <= norm_sticky;
    end
  end

  assign out_sticky = s2_sticky_q;
`else
  assign out_sticky = 1'b0;
`endif

  assign out_mant  = s2_mant_q;
  assign out_scale = s2_scale_q;
  assign out_guard = s2_guard_q;
  assign out_zero  = s2_zero_q;
  assign out_err   = s2_err_q;

endmodule

// File: tb/tb_mantissa_product_normalizer.sv
// Self-checking bench for mantissa_product_normalizer: directed vectors,
// randomized traffic against a behavioural model, back-to-back stall stream
// and mid-operation reset.

module tb_mantissa_product_normalizer;

  localparam int SW = 10;

`ifdef MANT_NORM_STICKY_EN
  localparam bit StickyOn = 1'b1;
`else
  localparam bit StickyOn = 1'b0;
`endif

  typedef struct packed {
    logic [27:0]        mant;
    logic signed [SW:0] scale;
    logic               guard;
    logic               sticky;
    logic               zero;
    logic               err;
  } res_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [55:0]          in_prod;
  logic signed [SW-1:0] in_scale;
  logic                 in_zero;
  logic                 out_valid;
  logic                 out_ready;
  logic [27:0]          out_mant;
  logic signed [SW:0]   out_scale;
  logic                 out_guard;
  logic                 out_sticky;
  logic                 out_zero;
  logic                 out_err;

  int n_tests = 0;
  int n_fail  = 0;

  res_t exp_q[$];
  res_t got;

  assign got = {out_mant, out_scale, out_guard, out_sticky, out_zero, out_err};

  mantissa_product_normalizer #(.SCALE_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prod    (in_prod),
    .in_scale   (in_scale),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mant   (out_mant),
    .out_scale  (out_scale),
    .out_guard  (out_guard),
    .out_sticky (out_sticky),
    .out_zero   (out_zero),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  // Reference: treat the product as a number and pick the window by magnitude.
  function automatic res_t model(input logic [55:0] p, input logic signed [SW-1:0] s,
                                 input logic z);
    res_t r;
    logic [55:0] two55, two54;
    r     = '0;
    two55 = 56'd1 << 55;
    two54 = 56'd1 << 54;
    if (z) begin
      r.zero = 1'b1;
    end else if (p >= two55) begin
      r.mant   = 28'(p / (56'd1 << 28));
      r.guard  = ((p / (56'd1 << 27)) % 2) == 1;
      r.sticky = (p % (56'd1 << 27)) != 0;
      r.scale  = s + 1;
    end else if (p >= two54) begin
      r.mant   = 28'(p / (56'd1 << 27));
      r.guard  = ((p / (56'd1 << 26)) % 2) == 1;
      r.sticky = (p % (56'd1 << 26)) != 0;
      r.scale  = s;
    end else begin
      r.err = 1'b1;
    end
    if (!StickyOn) r.sticky = 1'b0;
    return r;
  endfunction

  function automatic logic [55:0] gen_prod();
    logic [63:0] raw;
    logic [55:0] p;
    int kind;
    raw  = {$urandom, $urandom};
    p    = raw[55:0];
    kind = $urandom_range(0, 7);
    if (kind == 0)      p[55:54] = 2'b00;
    else if (kind < 4)  p[55] = 1'b1;
    else                p[55:54] = 2'b01;
    if ($urandom_range(0, 3) == 0) p[25:0] = '0;
    return p;
  endfunction

  // Scoreboard: sampled mid-cycle, so handshakes seen here complete at the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: got out_valid=1 mant=%h required no pending result",
                   out_mant);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL scoreboard: got m=%h sc=%0d g=%b s=%b z=%b e=%b required m=%h sc=%0d g=%b s=%b z=%b e=%b",
                     got.mant, got.scale, got.guard, got.sticky, got.zero, got.err,
                     e.mant, e.scale, e.guard, e.sticky, e.zero, e.err);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_prod, in_scale, in_zero));
    end
  end

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_scale  = '0;
    in_zero   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    n_tests++;
    if (got !== res_t'(0)) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h required 0", got);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [55:0]          d_prod [7];
    logic signed [SW-1:0] d_scale[7];
    logic                 d_zero [7];
    res_t                 d_exp  [7];
    d_prod[0] = 56'h80_0000_0000_0000; d_scale[0] = 10'h005; d_zero[0] = 1'b0;
    d_exp[0]  = {28'h800_0000, 11'h006, 1'b0, 1'b0, 1'b0, 1'b0};
    d_prod[1] = 56'h40_0000_0000_0001; d_scale[1] = 10'h3FD; d_zero[1] = 1'b0;
    d_exp[1]  = {28'h800_0000, 11'h7FD, 1'b0, StickyOn, 1'b0, 1'b0};
    d_prod[2] = 56'hFF_FFFF_FFFF_FFFF; d_scale[2] = 10'h123; d_zero[2] = 1'b1;
    d_exp[2]  = {28'h000_0000, 11'h000, 1'b0, 1'b0, 1'b1, 1'b0};
    d_prod[3] = 56'h10_0000_0000_0000; d_scale[3] = 10'h007; d_zero[3] = 1'b0;
    d_exp[3]  = {28'h000_0000, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1};
    d_prod[4] = 56'hFF_FFFF_FFFF_FFFF; d_scale[4] = 10'h1FF; d_zero[4] = 1'b0;
    d_exp[4]  = {28'hFFF_FFFF, 11'h200, 1'b1, StickyOn, 1'b0, 1'b0};
    d_prod[5] = 56'h40_0000_0400_0000; d_scale[5] = 10'h200; d_zero[5] = 1'b0;
    d_exp[5]  = {28'h800_0000, 11'h600, 1'b1, 1'b0, 1'b0, 1'b0};
    d_prod[6] = 56'h80_0000_0800_0000; d_scale[6] = 10'h000; d_zero[6] = 1'b0;
    d_exp[6]  = {28'h800_0000, 11'h001, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_prod   = d_prod[i];
      in_scale  = d_scale[i];
      in_zero   = d_zero[i];
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_in_ready[%0d]: got %b required 1", i, in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_early[%0d]: got out_valid=%b required 0", i, out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || got !== d_exp[i]) begin
        n_fail++;
        $display("FAIL directed[%0d]: got v=%b res=%h required v=1 res=%h",
                 i, out_valid, got, d_exp[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      // Upstream keeps a presented item stable until it is accepted.
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_prod  = gen_prod();
        in_scale = SW'($urandom_range(0, (1 << SW) - 1));
        in_zero  = ($urandom_range(0, 9) == 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      pending = in_valid && !in_ready;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || out_valid); c++) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d results outstanding required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int acc = 0;
    int cyc = 0;
    while ((idx < 10 || exp_q.size() != 0 || out_valid) && cyc < 100) begin
      @(posedge clk);
      #1;
      in_valid  = (idx < 10);
      in_prod   = gen_prod();
      in_scale  = SW'(idx * 37 + 1);
      in_zero   = 1'b0;
      out_ready = (cyc >= 4);
      @(negedge clk);
      if (in_valid && in_ready) begin
        idx++;
        if (cyc < 4) acc++;
      end
      if (cyc == 3) begin
        n_tests++;
        if (acc != 2 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_stall: got accepts=%0d in_ready=%b required accepts=2 in_ready=0",
                   acc, in_ready);
        end
      end
      cyc++;
    end
    n_tests++;
    if (idx != 10 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_complete: got sent=%0d outstanding=%0d required sent=10 outstanding=0",
               idx, exp_q.size());
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_prod  = gen_prod();
      in_scale = SW'(i + 100);
      in_zero  = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_full: got v=%b rdy=%b required v=1 rdy=0", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_after: got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
    end
    // Any stale result appearing now is caught by the scoreboard as unexpected.
    repeat (4) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_stale: got out_valid=%b required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
